// File: rtl/button_seq_pkg.sv
// Shared mode/LED-select encodings and counter sizing for the button sequencer.
// Pure types and constant functions; no logic of its own.
package button_seq_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'd0,
        MODE_RUN   = 2'd1,
        MODE_PAUSE = 2'd2,
        MODE_STEP  = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        LED_OFF       = 3'd0,
        LED_ON        = 3'd1,
        LED_HEARTBEAT = 3'd2,
        LED_FLAG      = 3'd3,
        LED_STRETCH   = 3'd4
    } led_sel_e;

    localparam logic [15:0] STRETCH_LOAD = 16'hFFFF;

    // Width of a counter that runs 0..n-1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic led_sel_e led1_sel(input mode_e m);
        return (m == MODE_IDLE) ? LED_HEARTBEAT : LED_FLAG;
    endfunction

    function automatic led_sel_e led2_sel(input mode_e m);
        led_sel_e sel;
        case (m)
            MODE_IDLE:  sel = LED_OFF;
            MODE_RUN:   sel = LED_ON;
            MODE_PAUSE: sel = LED_HEARTBEAT;
            MODE_STEP:  sel = LED_STRETCH;
            default:    sel = LED_OFF;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Button input conditioning: 2-flop sync, debounce, one-cycle pulse on accepted press.
// Pad edge to press_evt is 2 + DEBOUNCE_CYCLES + 1 cycles; shorter pulses are dropped.
module button_debounce
    import button_seq_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter bit          BUT_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic pad,
    output logic pressed,
    output logic press_evt
);

    localparam logic        RELEASED = BUT_ACTIVE_LOW;
    localparam int unsigned CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          armed_q, armed_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          prev_q, prev_d;
    logic          evt_q, evt_d;
    logic          pressed_now;

    assign pressed_now = armed_q && (level_q != RELEASED);

    // Until armed, the counter measures how long the pad has read released, so a
    // button still held across reset cannot generate a press until let go.
    always_comb begin
        level_d = level_q;
        armed_d = armed_q;
        cnt_d   = cnt_q;
        if (!armed_q) begin
            if (sync2_q != RELEASED) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                armed_d = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = ~level_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        prev_d = pressed_now;
        evt_d  = pressed_now && !prev_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= RELEASED;
            sync2_q <= RELEASED;
            level_q <= RELEASED;
            armed_q <= 1'b0;
            cnt_q   <= '0;
            prev_q  <= 1'b0;
            evt_q   <= 1'b0;
        end else begin
            sync1_q <= pad;
            sync2_q <= sync1_q;
            level_q <= level_d;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
            prev_q  <= prev_d;
            evt_q   <= evt_d;
        end
    end

    assign pressed   = pressed_now;
    assign press_evt = evt_q;

endmodule

// File: rtl/button_cond_sequencer.sv
// Mode FSM driving core cond0/cond1 from debounced buttons, plus heartbeat and LED mux.
// All outputs registered: they change one cycle after the press_evt that causes them.
module button_cond_sequencer
    import button_seq_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned BLINK_HALF      = 6000000,
    parameter bit          BUT_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       but1_pad,
    input  logic       but2_pad,
    input  logic       core_flag,
    output logic       cond0,
    output logic       cond1,
    output logic       led1,
    output logic       led2,
    output logic [1:0] mode
);

    localparam int unsigned HW = cnt_width(BLINK_HALF);
    localparam logic [HW-1:0] HB_LAST = HW'(BLINK_HALF - 1);

    logic but1_evt, but2_evt, but1_pressed, but2_pressed;
    logic unused_pressed;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .BUT_ACTIVE_LOW  (BUT_ACTIVE_LOW)
    ) u_deb1 (
        .clk       (clk),
        .reset     (reset),
        .pad       (but1_pad),
        .pressed   (but1_pressed),
        .press_evt (but1_evt)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .BUT_ACTIVE_LOW  (BUT_ACTIVE_LOW)
    ) u_deb2 (
        .clk       (clk),
        .reset     (reset),
        .pad       (but2_pad),
        .pressed   (but2_pressed),
        .press_evt (but2_evt)
    );

    assign unused_pressed = but1_pressed ^ but2_pressed;

    mode_e         state_q, state_d;
    logic          cond0_q, cond0_d, cond1_q, cond1_d;
    logic          led1_q, led1_d, led2_q, led2_d;
    logic [HW-1:0] hb_cnt_q, hb_cnt_d;
    logic          hb_q, hb_d;
    logic [15:0]   stretch_q, stretch_d;
    logic          b1, b2, step_pulse;

    function automatic logic led_pick(input led_sel_e sel, input logic hb,
                                      input logic flag, input logic stretch);
        logic v;
        case (sel)
            LED_ON:        v = 1'b1;
            LED_HEARTBEAT: v = hb;
            LED_FLAG:      v = flag;
            LED_STRETCH:   v = stretch;
            default:       v = 1'b0;
        endcase
        return v;
    endfunction

    // BUT1 has priority: a BUT2 event in the same cycle is dropped.
    assign b1 = but1_evt;
    assign b2 = but2_evt && !but1_evt;

    always_comb begin
        state_d = state_q;
        case (state_q)
            MODE_IDLE:  if (b1) state_d = MODE_RUN;
            MODE_RUN:   if (b1) state_d = MODE_STEP;  else if (b2) state_d = MODE_PAUSE;
            MODE_PAUSE: if (b1) state_d = MODE_STEP;  else if (b2) state_d = MODE_RUN;
            MODE_STEP:  if (b1) state_d = MODE_IDLE;
            default:    state_d = MODE_IDLE;
        endcase

        step_pulse = (state_q == MODE_STEP) && b2;
        cond0_d    = (state_d == MODE_RUN) || step_pulse;
        cond1_d    = (state_d != MODE_IDLE);

        if (hb_cnt_q == HB_LAST) begin
            hb_cnt_d = '0;
            hb_d     = ~hb_q;
        end else begin
            hb_cnt_d = hb_cnt_q + 1'b1;
            hb_d     = hb_q;
        end

        if (step_pulse)
            stretch_d = STRETCH_LOAD;
        else if (stretch_q != 16'd0)
            stretch_d = stretch_q - 16'd1;
        else
            stretch_d = 16'd0;

        led1_d = led_pick(led1_sel(state_d), hb_d, core_flag, stretch_d != 16'd0);
        led2_d = led_pick(led2_sel(state_d), hb_d, core_flag, stretch_d != 16'd0);
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= MODE_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cond0_q   <= 1'b0;
            cond1_q   <= 1'b0;
            led1_q    <= 1'b0;
            led2_q    <= 1'b0;
            hb_cnt_q  <= '0;
            hb_q      <= 1'b0;
            stretch_q <= 16'd0;
        end else begin
            cond0_q   <= cond0_d;
            cond1_q   <= cond1_d;
            led1_q    <= led1_d;
            led2_q    <= led2_d;
            hb_cnt_q  <= hb_cnt_d;
            hb_q      <= hb_d;
            stretch_q <= stretch_d;
        end
    end

    assign cond0 = cond0_q;
    assign cond1 = cond1_q;
    assign led1  = led1_q;
    assign led2  = led2_q;
    assign mode  = state_q;

endmodule

// File: tb/tb_button_cond_sequencer.sv
// Directed bench for button_cond_sequencer with DEBOUNCE_CYCLES=4, BLINK_HALF=8.
module tb_button_cond_sequencer;

    logic       clk = 1'b0;
    logic       reset, but1_pad, but2_pad, core_flag;
    logic       cond0, cond1, led1, led2;
    logic [1:0] mode;

    int checks = 0;
    int errors = 0;
    int highs, at;
    logic saw_pause, step_cond0;

    always #5 clk = ~clk;

    button_cond_sequencer #(
        .DEBOUNCE_CYCLES (4),
        .BLINK_HALF      (8),
        .BUT_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .but1_pad  (but1_pad),
        .but2_pad  (but2_pad),
        .core_flag (core_flag),
        .cond0     (cond0),
        .cond1     (cond1),
        .led1      (led1),
        .led2      (led2),
        .mode      (mode)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Press for 10 cycles (transition lands on the 8th edge), then release and settle.
    task automatic press(input int btn);
        if (btn == 1) but1_pad = 1'b0; else but2_pad = 1'b0;
        tick(10);
        but1_pad = 1'b1;
        but2_pad = 1'b1;
        tick(10);
    endtask

    initial begin
        reset = 1'b1; but1_pad = 1'b1; but2_pad = 1'b1; core_flag = 1'b0;
        tick(3);
        check("rst_mode",  16'(mode),  16'd0);
        check("rst_cond0", 16'(cond0), 16'd0);
        check("rst_cond1", 16'(cond1), 16'd0);
        check("rst_led1",  16'(led1),  16'd0);
        check("rst_led2",  16'(led2),  16'd0);

        // 1: idle heartbeat, led1 flips every 8 cycles
        reset = 1'b0;
        for (int n = 1; n <= 50; n++) begin
            tick(1);
            check("hb_led1", 16'(led1), 16'((n / 8) % 2));
        end
        check("idle_mode",  16'(mode),  16'd0);
        check("idle_cond0", 16'(cond0), 16'd0);
        check("idle_cond1", 16'(cond1), 16'd0);
        check("idle_led2",  16'(led2),  16'd0);

        // 2: 3-cycle glitch dropped, real press enters RUN after 2+4+1+1 edges
        but1_pad = 1'b0; tick(3); but1_pad = 1'b1; tick(10);
        check("glitch_mode", 16'(mode), 16'd0);
        but1_pad = 1'b0;
        tick(7);
        check("lat_pre_mode", 16'(mode), 16'd0);
        tick(1);
        check("run_mode",  16'(mode),  16'd1);
        check("run_cond0", 16'(cond0), 16'd1);
        check("run_cond1", 16'(cond1), 16'd1);
        check("run_led2",  16'(led2),  16'd1);
        check("run_led1",  16'(led1),  16'd0);
        tick(10);
        check("held_mode", 16'(mode), 16'd1);
        but1_pad = 1'b1; tick(10);
        check("release_mode", 16'(mode), 16'd1);

        // 3: RUN -> PAUSE -> RUN, led1 follows core_flag
        press(2);
        check("pause_mode",  16'(mode),  16'd2);
        check("pause_cond0", 16'(cond0), 16'd0);
        check("pause_cond1", 16'(cond1), 16'd1);
        core_flag = 1'b1; tick(1);
        check("pause_flag_on", 16'(led1), 16'd1);
        core_flag = 1'b0; tick(1);
        check("pause_flag_off", 16'(led1), 16'd0);
        press(2);
        check("resume_mode",  16'(mode),  16'd1);
        check("resume_cond0", 16'(cond0), 16'd1);

        // 4: RUN -> STEP, two BUT2 presses give two single-cycle cond0 pulses
        press(1);
        check("step_mode",  16'(mode),  16'd3);
        check("step_cond0", 16'(cond0), 16'd0);
        check("step_cond1", 16'(cond1), 16'd1);
        check("step_led2",  16'(led2),  16'd0);
        for (int p = 0; p < 2; p++) begin
            highs = 0; at = 0;
            but2_pad = 1'b0;
            for (int i = 1; i <= 20; i++) begin
                tick(1);
                if (cond0) begin highs++; at = i; end
                if (i == 10) but2_pad = 1'b1;
            end
            check("pulse_count", 16'(highs), 16'd1);
            check("pulse_pos",   16'(at),    16'd8);
            check("pulse_led2",  16'(led2),  16'd1);
            check("pulse_mode",  16'(mode),  16'd3);
        end

        // 5: STEP -> IDLE -> RUN, then both buttons together go to STEP
        press(1);
        check("back_idle_mode",  16'(mode),  16'd0);
        check("back_idle_led2",  16'(led2),  16'd0);
        check("back_idle_cond1", 16'(cond1), 16'd0);
        press(1);
        check("rerun_mode", 16'(mode), 16'd1);
        saw_pause = 1'b0; step_cond0 = 1'b0;
        but1_pad = 1'b0; but2_pad = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (mode == 2'd2) saw_pause = 1'b1;
            if (mode == 2'd3 && cond0) step_cond0 = 1'b1;
            if (i == 8) check("both_mode_at8", 16'(mode), 16'd3);
            if (i == 10) begin but1_pad = 1'b1; but2_pad = 1'b1; end
        end
        check("both_no_pause", 16'(saw_pause),  16'd0);
        check("both_no_pulse", 16'(step_cond0), 16'd0);
        check("both_mode",     16'(mode),       16'd3);
        check("both_cond1",    16'(cond1),      16'd1);

        // 6: reset mid-debounce in STEP with BUT1 held
        core_flag = 1'b1; tick(1);
        check("pre_rst_led1", 16'(led1), 16'd1);
        check("pre_rst_led2", 16'(led2), 16'd1);
        but1_pad = 1'b0; tick(4);
        reset = 1'b1; tick(1);
        check("mid_rst_mode",  16'(mode),  16'd0);
        check("mid_rst_cond0", 16'(cond0), 16'd0);
        check("mid_rst_cond1", 16'(cond1), 16'd0);
        check("mid_rst_led1",  16'(led1),  16'd0);
        check("mid_rst_led2",  16'(led2),  16'd0);
        reset = 1'b0; core_flag = 1'b0;
        tick(20);
        check("held_after_rst", 16'(mode), 16'd0);
        but1_pad = 1'b1; tick(10);
        check("released_after_rst", 16'(mode), 16'd0);
        press(1);
        check("repress_mode",  16'(mode),  16'd1);
        check("repress_cond0", 16'(cond0), 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
